hazard_stall_ctrl: RTL and testbench

- Pipeline interlock controller for the 5-stage Minisys-1A core, alongside the forwarding unit.
- Detects hazards that forwarding cannot resolve:
  - load-use,
  - branch-in-ID after a load,
  - multi-cycle mult/div occupancy of the EX stage.
- Drives freeze/bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences mult/div busy cycles with an internal counter FSM.

---
 rtl/hazard_stall_ctrl_pkg.sv | 24 ++
 rtl/hazard_stall_ctrl_if.sv | 65 ++++++
 rtl/hazard_stall_ctrl_muldiv_seq.sv | 97 +++++++++
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the Minisys-1A pipeline interlock controller.
//   md_state_e          : mult/div sequencer states (IDLE, BUSY, DONE)
//   REG_ZERO            : GPR $0, which never creates a dependency
//   *_DEFAULT constants : default EX-stage occupancy of mult/div and the
//                         busy counter width
// Optional feature macro used by the controller: HAZARD_PERF_EN.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULT_CYCLES_DEFAULT = 4;
    localparam int DIV_CYCLES_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT       = 6;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundle between the pipeline datapath and the interlock controller.
//   master : pipeline side, drives the ID/EX/MEM hazard fields, the mult/div
//            start strobes and Flush; receives the stall/bubble controls.
//   slave  : controller side (hazard_stall_ctrl).
// With HAZARD_PERF_EN defined the bundle also carries three 32-bit
// performance counters (Perf_LU_Cnt, Perf_BL_Cnt, Perf_MD_Cnt).
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if;

    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_UseRs;
    logic       ID_UseRt;
    logic       ID_Branch;
    logic       ID_MulDiv;
    logic       ID_EX_MemRead;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_waddr;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_waddr;
    logic       EX_MultStart;
    logic       EX_DivStart;
    logic       Flush;

    logic       PC_Stall;
    logic       IF_ID_Stall;
    logic       ID_EX_Stall;
    logic       ID_EX_Bubble;
    logic       EX_MEM_Bubble;
    logic       MulDiv_Busy;
    logic       MulDiv_Done;

`ifdef HAZARD_PERF_EN
    logic [31:0] Perf_LU_Cnt;
    logic [31:0] Perf_BL_Cnt;
    logic [31:0] Perf_MD_Cnt;
`endif

    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_MulDiv,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_waddr,
               EX_MEM_MemRead, EX_MEM_waddr,
               EX_MultStart, EX_DivStart, Flush,
`ifdef HAZARD_PERF_EN
        input  Perf_LU_Cnt, Perf_BL_Cnt, Perf_MD_Cnt,
`endif
        input  PC_Stall, IF_ID_Stall, ID_EX_Stall, ID_EX_Bubble,
               EX_MEM_Bubble, MulDiv_Busy, MulDiv_Done
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_MulDiv,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_waddr,
               EX_MEM_MemRead, EX_MEM_waddr,
               EX_MultStart, EX_DivStart, Flush,
`ifdef HAZARD_PERF_EN
        output Perf_LU_Cnt, Perf_BL_Cnt, Perf_MD_Cnt,
`endif
        output PC_Stall, IF_ID_Stall, ID_EX_Stall, ID_EX_Bubble,
               EX_MEM_Bubble, MulDiv_Busy, MulDiv_Done
    );

endinterface

// File: rtl/hazard_stall_ctrl_muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Mult/div EX-occupancy sequencer. A start loads the counter with N-2; the
// FSM then spends N-2 cycles in BUSY and one cycle in DONE, so together with
// the start cycle the EX stage is occupied for exactly N cycles.
// Ports:
//   clock, resetn  : core clock, asynchronous active-low reset
//   i_mult_start   : mult/multu entering EX
//   i_div_start    : div/divu entering EX (wins over i_mult_start)
//   i_flush        : abandon any in-flight operation, no Done
//   o_busy         : registered, FSM is in BUSY
//   o_done         : registered, FSM is in DONE (HI/LO write cycle)
// ---------------------------------------------------------------------------
module muldiv_seq
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_mult_start,
    input  logic i_div_start,
    input  logic i_flush,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // A start is only accepted from IDLE or DONE; DONE + start gives a
    // back-to-back operation. A zero load (N=2) skips BUSY entirely.
    // The BUSY exit fires when the counter is about to decrement to zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_div_start || i_mult_start) begin
                        r_cnt <= i_div_start ? DIV_LOAD : MULT_LOAD;
                        if ((i_div_start ? DIV_LOAD : MULT_LOAD) == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline interlock controller for the 5-stage Minisys-1A core. Detects the
// hazards forwarding cannot cover (load-use, branch-in-ID after a load,
// mult/div EX occupancy) and drives the PC / IF/ID / ID/EX / EX/MEM
// freeze and bubble controls.
// Ports:
//   clock, resetn : core clock, asynchronous active-low reset
//   hz (slave)    : hazard fields in, stall/bubble/busy/done out
// Optional feature macro HAZARD_PERF_EN: adds the Perf_LU_Cnt, Perf_BL_Cnt
// and Perf_MD_Cnt cycle counters (cleared by reset only, wrap at 2^32).
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input logic           clock,
    input logic           resetn,
    hazard_stall_ctrl_if.slave hz
);

    logic r_armed;
    logic w_md_busy;
    logic w_md_done;
    logic w_lu;
    logic w_bl;
    logic w_live;
    logic w_start;
    logic w_freeze;
    logic w_hazard;
    logic w_unused_id_muldiv;

    // Keeps every output low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // mfhi/mflo need no interlock of their own: they are held by the
    // occupancy freeze and read HI/LO through forwarding after DONE.
    assign w_unused_id_muldiv = hz.ID_MulDiv;

    assign w_lu = hz.ID_EX_MemRead & hz.ID_EX_RegWrite &
                  (hz.ID_EX_waddr != REG_ZERO) &
                  ((hz.ID_UseRs & (hz.ID_rs == hz.ID_EX_waddr)) |
                   (hz.ID_UseRt & (hz.ID_rt == hz.ID_EX_waddr)));

    assign w_bl = hz.ID_Branch & hz.EX_MEM_MemRead &
                  (hz.EX_MEM_waddr != REG_ZERO) &
                  ((hz.ID_UseRs & (hz.ID_rs == hz.EX_MEM_waddr)) |
                   (hz.ID_UseRt & (hz.ID_rt == hz.EX_MEM_waddr)));

    muldiv_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_muldiv_seq (
        .clock        (clock),
        .resetn       (resetn),
        .i_mult_start (r_armed & hz.EX_MultStart),
        .i_div_start  (r_armed & hz.EX_DivStart),
        .i_flush      (hz.Flush),
        .o_busy       (w_md_busy),
        .o_done       (w_md_done)
    );

    // Priority: Flush, then mult/div freeze (start cycle or BUSY), then
    // load hazards. The DONE cycle freezes nothing, so a load hazard that was
    // masked during BUSY is seen again there and never lost.
    assign w_live   = r_armed & ~hz.Flush;
    assign w_start  = w_live & ~w_md_busy & (hz.EX_MultStart | hz.EX_DivStart);
    assign w_freeze = w_live & (w_md_busy | w_start);
    assign w_hazard = w_live & ~w_freeze & (w_lu | w_bl);

    assign hz.PC_Stall      = w_freeze | w_hazard;
    assign hz.IF_ID_Stall   = w_freeze | w_hazard;
    assign hz.ID_EX_Stall   = w_freeze;
    assign hz.ID_EX_Bubble  = w_hazard;
    assign hz.EX_MEM_Bubble = w_freeze;
    assign hz.MulDiv_Busy   = w_freeze;
    assign hz.MulDiv_Done   = w_live & w_md_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_bl;
    logic [31:0] r_perf_md;

    // Flush does not clear these; only reset does.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_perf_lu <= '0;
            r_perf_bl <= '0;
            r_perf_md <= '0;
        end else begin
            if (w_hazard & w_lu) r_perf_lu <= r_perf_lu + 32'd1;
            if (w_hazard & w_bl) r_perf_bl <= r_perf_bl + 32'd1;
            if (w_freeze)        r_perf_md <= r_perf_md + 32'd1;
        end
    end

    assign hz.Perf_LU_Cnt = r_perf_lu;
    assign hz.Perf_BL_Cnt = r_perf_bl;
    assign hz.Perf_MD_Cnt = r_perf_md;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed and random stimulus for hazard_stall_ctrl. The reference model
// tracks a mult/div as "accepted at cycle t, Done at cycle t+N-1" and derives
// the expected controls from the hazard rules each cycle.
// With HAZARD_PERF_EN defined the performance counters are also compared.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    typedef struct {
        logic       rstn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic       branch;
        logic       mulDiv;
        logic       exLoad;
        logic       exRegWrite;
        logic [4:0] exWaddr;
        logic       memLoad;
        logic [4:0] memWaddr;
        logic       multStart;
        logic       divStart;
        logic       flush;
    } stim_t;

    logic clock = 1'b0;
    logic resetn;

    int assertCount;
    int failCount;

    int cycleNo;
    bit mArmed;
    bit mActive;
    int mDoneAt;
    int mLu;
    int mBl;
    int mMd;

    bit eStart;
    bit eFreeze;
    bit eStall;
    bit eIsDone;
    bit eLu;
    bit eBl;
    logic oFreeze;
    logic oDone;

    always #5 clock = ~clock;

    hazard_stall_ctrl_if hz ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .hz     (hz)
    );

    function automatic stim_t nopStim();
        stim_t s;
        s.rstn = 1'b1;   s.rs = '0;        s.rt = '0;
        s.useRs = 1'b0;  s.useRt = 1'b0;   s.branch = 1'b0;
        s.mulDiv = 1'b0; s.exLoad = 1'b0;  s.exRegWrite = 1'b0;
        s.exWaddr = '0;  s.memLoad = 1'b0; s.memWaddr = '0;
        s.multStart = 1'b0; s.divStart = 1'b0; s.flush = 1'b0;
        return s;
    endfunction

    function automatic stim_t luStim(input logic [4:0] dst);
        stim_t s;
        s = nopStim();
        s.exLoad = 1'b1; s.exRegWrite = 1'b1; s.exWaddr = dst;
        s.rs = 5'd3;     s.useRs = 1'b1;      s.rt = 5'd9; s.useRt = 1'b1;
        return s;
    endfunction

    function automatic bit dependsOn(input logic [4:0] w);
        return (w != 5'd0) &&
               ((hz.ID_UseRs && hz.ID_rs == w) || (hz.ID_UseRt && hz.ID_rt == w));
    endfunction

    task automatic modelReset();
        mArmed = 0; mActive = 0; mLu = 0; mBl = 0; mMd = 0;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input longint obs, input longint exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        resetn            = s.rstn;
        hz.ID_rs          = s.rs;
        hz.ID_rt          = s.rt;
        hz.ID_UseRs       = s.useRs;
        hz.ID_UseRt       = s.useRt;
        hz.ID_Branch      = s.branch;
        hz.ID_MulDiv      = s.mulDiv;
        hz.ID_EX_MemRead  = s.exLoad;
        hz.ID_EX_RegWrite = s.exRegWrite;
        hz.ID_EX_waddr    = s.exWaddr;
        hz.EX_MEM_MemRead = s.memLoad;
        hz.EX_MEM_waddr   = s.memWaddr;
        hz.EX_MultStart   = s.multStart;
        hz.EX_DivStart    = s.divStart;
        hz.Flush          = s.flush;
    endtask

    // Expected controls for the current cycle, from the hazard rules and the
    // model's record of when the in-flight mult/div completes.
    task automatic checkOutput();
        bit live;
        bit inFlight;
        bit eDone;
        eLu = hz.ID_EX_MemRead && hz.ID_EX_RegWrite && dependsOn(hz.ID_EX_waddr);
        eBl = hz.ID_Branch && hz.EX_MEM_MemRead && dependsOn(hz.EX_MEM_waddr);
        live     = (resetn === 1'b1) && mArmed && !hz.Flush;
        inFlight = mActive && (cycleNo < mDoneAt);
        eIsDone  = mActive && (cycleNo == mDoneAt);
        eStart   = live && !inFlight && (hz.EX_MultStart || hz.EX_DivStart);
        eFreeze  = live && (inFlight || eStart);
        eStall   = live && !eFreeze && (eLu || eBl);
        eDone    = live && eIsDone;
        checkBit("PC_Stall",      hz.PC_Stall,      eFreeze || eStall);
        checkBit("IF_ID_Stall",   hz.IF_ID_Stall,   eFreeze || eStall);
        checkBit("ID_EX_Stall",   hz.ID_EX_Stall,   eFreeze);
        checkBit("ID_EX_Bubble",  hz.ID_EX_Bubble,  eStall);
        checkBit("EX_MEM_Bubble", hz.EX_MEM_Bubble, eFreeze);
        checkBit("MulDiv_Busy",   hz.MulDiv_Busy,   eFreeze);
        checkBit("MulDiv_Done",   hz.MulDiv_Done,   eDone);
        oFreeze = hz.MulDiv_Busy;
        oDone   = hz.MulDiv_Done;
    endtask

    task automatic advanceModel();
        if (resetn !== 1'b1) begin
            modelReset();
        end else begin
            if (hz.Flush) begin
                mActive = 0;
            end else if (eStart) begin
                mActive = 1;
                mDoneAt = cycleNo + (hz.EX_DivStart ? DIV_N : MULT_N) - 1;
            end else if (eIsDone) begin
                mActive = 0;
            end
            if (eStall && eLu) mLu++;
            if (eStall && eBl) mBl++;
            if (eFreeze)       mMd++;
            mArmed = 1;
        end
        cycleNo++;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clock);
        driveInputs(s);
        #1;
        checkOutput();
        @(posedge clock);
        advanceModel();
    endtask

    initial begin
        stim_t s;
        int freezeCnt;
        int doneIdx;
        int gaps;
        int d1;
        int d2;
        int doneCnt;

        assertCount = 0;
        failCount   = 0;
        cycleNo     = 0;
        modelReset();
        s = nopStim();
        s.rstn = 1'b0;
        driveInputs(s);

        $display("[TB] reset with hazard inputs present");
        s = luStim(5'd3);
        s.rstn = 1'b0;
        s.multStart = 1'b1;
        repeat (2) applyStimulus(s);
        applyStimulus(luStim(5'd3));

        $display("[TB] load-use");
        applyStimulus(luStim(5'd3));
        applyStimulus(nopStim());
        applyStimulus(luStim(5'd0));
        s = luStim(5'd3);
        s.useRs = 1'b0;
        applyStimulus(s);

        $display("[TB] load followed by dependent branch");
        s = nopStim();
        s.exLoad = 1'b1; s.exRegWrite = 1'b1; s.exWaddr = 5'd5;
        s.rs = 5'd5; s.rt = 5'd6; s.useRs = 1'b1; s.useRt = 1'b1; s.branch = 1'b1;
        applyStimulus(s);
        s.exLoad = 1'b0; s.exRegWrite = 1'b0; s.exWaddr = 5'd0;
        s.memLoad = 1'b1; s.memWaddr = 5'd5;
        applyStimulus(s);
        s.memLoad = 1'b0; s.memWaddr = 5'd0;
        applyStimulus(s);

        $display("[TB] div occupancy with mfhi waiting in ID");
        freezeCnt = 0;
        doneIdx = -1;
        for (int k = 0; k < DIV_N + 4; k++) begin
            s = nopStim();
            s.mulDiv = 1'b1;
            s.divStart = (k == 0);
            applyStimulus(s);
            if (oFreeze) freezeCnt++;
            if (oDone) doneIdx = k;
        end
        checkInt("div_freeze_cycles", freezeCnt, DIV_N - 1);
        checkInt("div_done_cycle", doneIdx + 1, DIV_N);

        $display("[TB] mult then back-to-back div");
        gaps = 0; d1 = -1; d2 = -1;
        for (int k = 0; k < MULT_N + DIV_N + 3; k++) begin
            s = nopStim();
            s.multStart = (k == 0);
            s.divStart  = (k == MULT_N - 1);
            applyStimulus(s);
            if (k <= (MULT_N - 1) + (DIV_N - 2) && !oFreeze) gaps++;
            if (oDone) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        checkInt("b2b_busy_gaps", gaps, 0);
        checkInt("b2b_first_done", d1, MULT_N - 1);
        checkInt("b2b_done_spacing", d2 - d1, DIV_N - 1);

        $display("[TB] flush during div");
        doneCnt = 0; freezeCnt = 0;
        for (int k = 0; k < 21 + 40; k++) begin
            s = nopStim();
            s.divStart = (k == 0);
            s.flush = (k == 21);
            applyStimulus(s);
            if (k >= 21 && oDone) doneCnt++;
            if (k >= 21 && oFreeze) freezeCnt++;
        end
        checkInt("flush_no_done", doneCnt, 0);
        checkInt("flush_no_freeze", freezeCnt, 0);

        $display("[TB] asynchronous reset during div");
        s = nopStim();
        s.divStart = 1'b1;
        applyStimulus(s);
        repeat (10) applyStimulus(nopStim());
        @(negedge clock);
        driveInputs(nopStim());
        #2;
        resetn = 1'b0;
        #1;
        checkOutput();
        @(posedge clock);
        advanceModel();
        s = nopStim();
        s.rstn = 1'b0;
        applyStimulus(s);
        applyStimulus(luStim(5'd3));

        $display("[TB] three load-use stalls and one mult");
        doneCnt = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(luStim(5'd3));
            applyStimulus(nopStim());
        end
        s = nopStim();
        s.multStart = 1'b1;
        applyStimulus(s);
        for (int k = 0; k < MULT_N + 2; k++) begin
            applyStimulus(nopStim());
            if (oDone) doneCnt++;
        end
        checkInt("mult_done_pulses", doneCnt, 1);
`ifdef HAZARD_PERF_EN
        checkInt("Perf_LU_Cnt", hz.Perf_LU_Cnt, 3);
        checkInt("Perf_BL_Cnt", hz.Perf_BL_Cnt, 0);
        checkInt("Perf_MD_Cnt", hz.Perf_MD_Cnt, MULT_N - 1);
`endif

        $display("[TB] random stimulus");
        for (int k = 0; k < 1500; k++) begin
            s = nopStim();
            s.rstn       = ($urandom_range(0, 400) != 0);
            s.rs         = 5'($urandom_range(0, 3));
            s.rt         = 5'($urandom_range(0, 3));
            s.useRs      = 1'($urandom_range(0, 1));
            s.useRt      = 1'($urandom_range(0, 1));
            s.branch     = ($urandom_range(0, 2) == 0);
            s.mulDiv     = ($urandom_range(0, 4) == 0);
            s.exLoad     = ($urandom_range(0, 2) == 0);
            s.exRegWrite = ($urandom_range(0, 3) != 0);
            s.exWaddr    = 5'($urandom_range(0, 3));
            s.memLoad    = ($urandom_range(0, 2) == 0);
            s.memWaddr   = 5'($urandom_range(0, 3));
            s.multStart  = ($urandom_range(0, 12) == 0);
            s.divStart   = ($urandom_range(0, 40) == 0);
            s.flush      = ($urandom_range(0, 60) == 0);
            applyStimulus(s);
        end
`ifdef HAZARD_PERF_EN
        checkInt("rand_Perf_LU_Cnt", hz.Perf_LU_Cnt, mLu);
        checkInt("rand_Perf_BL_Cnt", hz.Perf_BL_Cnt, mBl);
        checkInt("rand_Perf_MD_Cnt", hz.Perf_MD_Cnt, mMd);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
